// File: rtl/tt_um_ha_bist.sv
// Self-test engine for the half-adder tile: walks all four {b,a} vectors,
// waits N settle cycles, samples {carry,sum} and reports pass/fail plus a mask.
module tt_um_ha_bist (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

   state_t     state;
   logic       start_q;
   logic [1:0] vec;
   logic [1:0] drv;
   logic [3:0] cnt;
   logic [3:0] settle_n;
   logic [3:0] wmask;
   logic [3:0] res_mask;
   logic       loop_q;
   logic       inject_q;
   logic       cont_q;
   logic       res_pass;
   logic       res_fail;

   logic       rise;
   logic       a;
   logic       b;
   logic [1:0] expected;
   logic [1:0] model;
   logic [1:0] observed;
   logic       miss;
   logic [3:0] next_mask;
   logic       busy;
   logic       done;
   logic       unused_bits;

   assign rise     = ui_in[0] & ~start_q;
   assign a        = vec[0];
   assign b        = vec[1];
   assign expected = {a & b, a ^ b};
   // Loopback model; the injected fault only corrupts sum on the last vector.
   assign model    = {a & b, (a ^ b) ^ (inject_q & (vec == 2'd3))};
   assign observed = loop_q ? model : uio_in[3:2];
   assign miss     = (observed != expected);
   assign next_mask = wmask | ({3'b000, miss} << vec);

   assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
   assign done = (state == DONE);

   assign uo_out  = {res_mask, res_fail, res_pass, done, busy};
   assign uio_out = {6'b000000, drv};
   assign uio_oe  = 8'h03;

   assign unused_bits = ^{uio_in[7:4], uio_in[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         vec      <= 2'd0;
         drv      <= 2'd0;
         cnt      <= 4'd0;
         settle_n <= 4'd0;
         wmask    <= 4'd0;
         res_mask <= 4'd0;
         loop_q   <= 1'b0;
         inject_q <= 1'b0;
         cont_q   <= 1'b0;
         res_pass <= 1'b0;
         res_fail <= 1'b0;
      end else if (ena) begin
         start_q <= ui_in[0];
         case (state)
            IDLE: begin
               if (rise) begin
                  loop_q   <= ui_in[1];
                  inject_q <= ui_in[2];
                  cont_q   <= ui_in[3];
                  settle_n <= ui_in[7:4];
                  vec      <= 2'd0;
                  drv      <= 2'd0;
                  wmask    <= 4'd0;
                  state    <= DRIVE;
               end
            end
            DRIVE: begin
               cnt   <= settle_n;
               state <= (settle_n != 4'd0) ? SETTLE : SAMPLE;
            end
            SETTLE: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= SAMPLE;
            end
            SAMPLE: begin
               wmask <= next_mask;
               if (vec == 2'd3) begin
                  res_mask <= next_mask;
                  res_pass <= (next_mask == 4'd0);
                  res_fail <= (next_mask != 4'd0);
                  drv      <= 2'd0;
                  state    <= DONE;
               end else begin
                  vec   <= vec + 2'd1;
                  drv   <= vec + 2'd1;
                  state <= DRIVE;
               end
            end
            DONE: begin
               // Continuous runs restart with the settings latched originally.
               if (cont_q) begin
                  vec   <= 2'd0;
                  drv   <= 2'd0;
                  wmask <= 4'd0;
                  state <= DRIVE;
               end else if (rise) begin
                  loop_q   <= ui_in[1];
                  inject_q <= ui_in[2];
                  cont_q   <= ui_in[3];
                  settle_n <= ui_in[7:4];
                  vec      <= 2'd0;
                  drv      <= 2'd0;
                  wmask    <= 4'd0;
                  state    <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_um_ha_bist.sv
// Directed bench for tt_um_ha_bist: loopback, injected fault, external
// half-adder models, continuous mode, enable freeze and mid-run reset.
module tb_tt_um_ha_bist;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks;
   int n_fail;
   int fault_mode;   // 0 correct, 1 carry stuck-at-0, 2 sum stuck-at-1

   tt_um_ha_bist dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External half adder hanging off the bidirectional pins.
   always_comb begin
      logic s;
      logic c;
      s = uio_out[0] ^ uio_out[1];
      c = uio_out[0] & uio_out[1];
      if (fault_mode == 1) c = 1'b0;
      if (fault_mode == 2) s = 1'b1;
      uio_in = {4'b0000, c, s, 2'b00};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] cfg);
      ui_in = cfg | 8'h01;
      step();
      ui_in = cfg & 8'hFE;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      while (!uo_out[1] && cycles < limit) begin
         step();
         cycles++;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      ui_in = 8'h00;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      ui_in = 8'($urandom_range(0, 255));
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo: got %h expected 00", uo_out); end
      n_checks++;
      if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
      n_checks++;
      if (uio_oe !== 8'h03) begin n_fail++; $display("FAIL reset_uio_oe: got %h expected 03", uio_oe); end
      step();
      ui_in = 8'($urandom_range(0, 255)) & 8'hFE;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if (uo_out !== 8'h00) begin n_fail++; $display("FAIL idle_uo: got %h expected 00", uo_out); end
      n_checks++;
      if (uio_out !== 8'h00) begin n_fail++; $display("FAIL idle_uio_out: got %h expected 00", uio_out); end
      ui_in = 8'h00;
      step();
   endtask

   task automatic test_loop_n0();
      do_start(8'h02);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (uo_out[0] !== 1'b1) begin n_fail++; $display("FAIL loop_busy[%0d]: got %b expected 1", i, uo_out[0]); end
         n_checks++;
         if (uio_out !== 8'(i / 2)) begin n_fail++; $display("FAIL loop_vec[%0d]: got %h expected %h", i, uio_out, i / 2); end
         step();
      end
      n_checks++;
      if (uo_out !== 8'h06) begin n_fail++; $display("FAIL loop_result: got %h expected 06", uo_out); end
      n_checks++;
      if (uio_out !== 8'h00) begin n_fail++; $display("FAIL loop_uio_idle: got %h expected 00", uio_out); end
   endtask

   task automatic test_inject();
      int cycles;
      do_start(8'h36);
      wait_done(100, cycles);
      n_checks++;
      if (cycles !== 20) begin n_fail++; $display("FAIL inject_latency: got %0d expected 20", cycles); end
      n_checks++;
      if (uo_out !== 8'h8A) begin n_fail++; $display("FAIL inject_result: got %h expected 8a", uo_out); end
   endtask

   task automatic test_external();
      int cycles;
      logic [7:0] exp_uo [3];
      exp_uo[0] = 8'h06;
      exp_uo[1] = 8'h8A;
      exp_uo[2] = 8'h9A;
      for (int m = 0; m < 3; m++) begin
         fault_mode = m;
         do_start(8'h20);
         wait_done(100, cycles);
         n_checks++;
         if (cycles !== 16) begin n_fail++; $display("FAIL ext_latency[%0d]: got %0d expected 16", m, cycles); end
         n_checks++;
         if (uo_out !== exp_uo[m]) begin n_fail++; $display("FAIL ext_result[%0d]: got %h expected %h", m, uo_out, exp_uo[m]); end
      end
      fault_mode = 0;
   endtask

   task automatic test_continuous();
      int last_done;
      int pulses;
      // Carry fault on the pins: a wrongly re-latched loop_int would show as fail.
      fault_mode = 1;
      last_done = 0;
      pulses = 0;
      do_start(8'h1A);
      for (int cyc = 1; cyc <= 60; cyc++) begin
         step();
         if (cyc == 5 || cyc == 31) ui_in = 8'h01;
         else ui_in = 8'h1A & 8'hFE;
         if (uo_out[1]) begin
            pulses++;
            n_checks++;
            if (cyc - last_done !== ((pulses == 1) ? 12 : 13)) begin
               n_fail++;
               $display("FAIL cont_period[%0d]: got %0d expected %0d", pulses, cyc - last_done, (pulses == 1) ? 12 : 13);
            end
            n_checks++;
            if (uo_out !== 8'h06) begin n_fail++; $display("FAIL cont_result[%0d]: got %h expected 06", pulses, uo_out); end
            last_done = cyc;
         end
      end
      n_checks++;
      if (pulses !== 4) begin n_fail++; $display("FAIL cont_pulses: got %0d expected 4", pulses); end
      fault_mode = 0;
   endtask

   task automatic test_ena_freeze();
      int cycles;
      apply_reset();
      do_start(8'h02);
      for (int i = 0; i < 3; i++) step();
      ena = 1'b0;
      for (int i = 0; i < 5; i++) step();
      n_checks++;
      if (uo_out !== 8'h01) begin n_fail++; $display("FAIL ena_uo: got %h expected 01", uo_out); end
      n_checks++;
      if (uio_out !== 8'h01) begin n_fail++; $display("FAIL ena_vec: got %h expected 01", uio_out); end
      ena = 1'b1;
      wait_done(100, cycles);
      n_checks++;
      if (cycles !== 5) begin n_fail++; $display("FAIL ena_remaining: got %0d expected 5", cycles); end
      n_checks++;
      if (uo_out !== 8'h06) begin n_fail++; $display("FAIL ena_result: got %h expected 06", uo_out); end
   endtask

   task automatic test_reset_mid();
      int busy_cycles;
      apply_reset();
      do_start(8'h32);
      for (int i = 0; i < 11; i++) step();
      n_checks++;
      if (uio_out !== 8'h02) begin n_fail++; $display("FAIL mid_vec: got %h expected 02", uio_out); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (uo_out !== 8'h00) begin n_fail++; $display("FAIL mid_reset_uo: got %h expected 00", uo_out); end
      n_checks++;
      if (uio_out !== 8'h00) begin n_fail++; $display("FAIL mid_reset_uio: got %h expected 00", uio_out); end
      step();
      rst_n = 1'b1;
      step();
      do_start(8'h02);
      busy_cycles = 0;
      while (uo_out[0] && busy_cycles < 50) begin
         busy_cycles++;
         step();
      end
      n_checks++;
      if (busy_cycles !== 8) begin n_fail++; $display("FAIL restart_busy: got %0d expected 8", busy_cycles); end
      n_checks++;
      if (uo_out !== 8'h06) begin n_fail++; $display("FAIL restart_result: got %h expected 06", uo_out); end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      fault_mode = 0;
      ena        = 1'b1;
      ui_in      = 8'h00;
      rst_n      = 1'b1;
      #2;
      test_reset();
      test_loop_n0();
      test_inject();
      test_external();
      test_continuous();
      test_ena_freeze();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
